// File: rtl/usb_utm_tx_if.sv
// UTMI transmit-side bundle: word handshake toward the link layer plus the
// frontend line drive toward the transceiver.
interface usb_utm_tx_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] tx_data;
   logic              tx_valid;
   logic              tx_valid_h;
   logic              tx_ready;
   logic              tx_active;
   logic              fe_dp;
   logic              fe_dn;
   logic              fe_oe;

   // Link-layer side: supplies words, receives handshake and line status.
   modport master (
      output tx_data, tx_valid, tx_valid_h,
      input  tx_ready, tx_active, fe_dp, fe_dn, fe_oe
   );

   // Transmitter side.
   modport slave (
      input  tx_data, tx_valid, tx_valid_h,
      output tx_ready, tx_active, fe_dp, fe_dn, fe_oe
   );
endinterface

// File: rtl/usb_utm_tx.sv
// Full-speed UTM transmit path: SYNC, bit stuffing, NRZI and EOP generation
// from one oversampled clock. Line outputs only change on bit-strobe edges.
module usb_utm_tx #(
   parameter int DATA_W      = 8,
   parameter int CLK_PER_BIT = 4
) (
   input logic         clk,
   input logic         rst,
   usb_utm_tx_if.slave bus
);
   localparam int CW = $clog2(CLK_PER_BIT);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLK_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_PRE  = CW'(CLK_PER_BIT - 2);

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_SYNC = 3'd1;
   localparam logic [2:0] ST_DATA = 3'd2;
   localparam logic [2:0] ST_SE0  = 3'd3;
   localparam logic [2:0] ST_EOPJ = 3'd4;

   logic [2:0]        state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic [4:0]        left_q, left_d;    // data bits still to send after the current one
   logic [2:0]        ones_q, ones_d;    // consecutive ones, including the current bit
   logic              line_q, line_d;    // NRZI level, 1 = J
   logic              eop_q, eop_d;      // second SE0 bit in progress
   logic              dp_q, dp_d;
   logic              dn_q, dn_d;
   logic              oe_q, oe_d;
   logic              active_q, active_d;
   logic              rdy_q, rdy_d;      // next cycle is the last clk before a word boundary

   logic strobe_s;
   logic emit_s;
   logic bit_s;
   logic wide_s;

   assign strobe_s = (cnt_q == CNT_LAST);
   assign wide_s   = (DATA_W == 16) && bus.tx_valid_h;

   // The boundary window is known one cycle ahead, but whether a DATA word
   // boundary actually hands over depends on tx_valid in that very cycle.
   // The SYNC boundary always pulses, even for an empty packet.
   assign bus.tx_ready  = rdy_q & ((state_q == ST_SYNC) | bus.tx_valid);
   assign bus.tx_active = active_q;
   assign bus.fe_dp     = dp_q;
   assign bus.fe_dn     = dn_q;
   assign bus.fe_oe     = oe_q;

   // Next-state, bit selection (stuff / shift / load) and NRZI line encoding.
   always_comb begin
      state_d  = state_q;
      shreg_d  = shreg_q;
      left_d   = left_q;
      ones_d   = ones_q;
      line_d   = line_q;
      eop_d    = eop_q;
      dp_d     = dp_q;
      dn_d     = dn_q;
      oe_d     = oe_q;
      active_d = active_q;
      rdy_d    = 1'b0;
      emit_s   = 1'b0;
      bit_s    = 1'b0;

      if (state_q == ST_IDLE || strobe_s) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end

      case (state_q)
         ST_IDLE: begin
            if (bus.tx_valid) begin
               // First SYNC bit (0) goes out now; the remaining seven come from 8'h80 >> 1.
               state_d  = ST_SYNC;
               shreg_d  = DATA_W'(8'h40);
               left_d   = 5'd7;
               oe_d     = 1'b1;
               active_d = 1'b1;
               emit_s   = 1'b1;
               bit_s    = 1'b0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SYNC, ST_DATA: begin
            rdy_d = (cnt_q == CNT_PRE) && (left_q == 5'd0) && (ones_q != 3'd6);
            if (strobe_s) begin
               if (ones_q == 3'd6) begin
                  // Stuffed zero; shifting pauses for this bit time.
                  emit_s = 1'b1;
                  bit_s  = 1'b0;
               end else if (left_q != 5'd0) begin
                  emit_s  = 1'b1;
                  bit_s   = shreg_q[0];
                  shreg_d = shreg_q >> 1;
                  left_d  = left_q - 5'd1;
               end else if (bus.tx_valid) begin
                  emit_s  = 1'b1;
                  bit_s   = bus.tx_data[0];
                  shreg_d = bus.tx_data >> 1;
                  left_d  = wide_s ? 5'd15 : 5'd7;
                  state_d = ST_DATA;
               end else begin
                  state_d = ST_SE0;
                  eop_d   = 1'b0;
                  dp_d    = 1'b0;
                  dn_d    = 1'b0;
               end
            end else begin
               state_d = state_q;
            end
         end
         ST_SE0: begin
            if (strobe_s) begin
               if (eop_q) begin
                  state_d = ST_EOPJ;
                  dp_d    = 1'b1;
                  dn_d    = 1'b0;
               end else begin
                  eop_d = 1'b1;
               end
            end else begin
               state_d = ST_SE0;
            end
         end
         ST_EOPJ: begin
            if (strobe_s) begin
               state_d  = ST_IDLE;
               oe_d     = 1'b0;
               active_d = 1'b0;
               line_d   = 1'b1;
               ones_d   = 3'd0;
               dp_d     = 1'b1;
               dn_d     = 1'b0;
            end else begin
               state_d = ST_EOPJ;
            end
         end
         default: begin
            state_d  = ST_IDLE;
            oe_d     = 1'b0;
            active_d = 1'b0;
            line_d   = 1'b1;
            ones_d   = 3'd0;
            dp_d     = 1'b1;
            dn_d     = 1'b0;
         end
      endcase

      if (emit_s) begin
         if (bit_s) begin
            ones_d = ones_q + 3'd1;
            line_d = line_q;
         end else begin
            ones_d = 3'd0;
            line_d = ~line_q;
         end
         dp_d = line_d;
         dn_d = ~line_d;
      end else begin
         ones_d = ones_d;
      end
   end

   // State and output registers; reset forces the idle J level with the driver off.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         shreg_q  <= '0;
         left_q   <= 5'd0;
         ones_q   <= 3'd0;
         line_q   <= 1'b1;
         eop_q    <= 1'b0;
         dp_q     <= 1'b1;
         dn_q     <= 1'b0;
         oe_q     <= 1'b0;
         active_q <= 1'b0;
         rdy_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         shreg_q  <= shreg_d;
         left_q   <= left_d;
         ones_q   <= ones_d;
         line_q   <= line_d;
         eop_q    <= eop_d;
         dp_q     <= dp_d;
         dn_q     <= dn_d;
         oe_q     <= oe_d;
         active_q <= active_d;
         rdy_q    <= rdy_d;
      end
   end
endmodule
